// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared defaults, CPU index type and modulo-N index helper.
package imem_arb_pkg;
  localparam int N_CPUS_DEF = 3;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int IDX_W = N_CPUS_DEF > 1 ? $clog2(N_CPUS_DEF) : 1;
  typedef logic [IDX_W-1:0] cpu_idx_t;
  function automatic int unsigned next_idx(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/fetch_rr_picker.sv
// fetch_rr_picker: first eligible CPU at or after ptr, wrapping at N.
module fetch_rr_picker #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx,
  output logic [N-1:0]  gnt_oh
);
  always_comb begin
    int j;
    logic [IW-1:0] ji;
    j = 0;
    ji = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Scan farthest-first so the candidate closest to ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= N ? j - N : j;
      ji = IW'(j);
      if (elig[ji]) begin
        gnt_vld = 1'b1;
        gnt_idx = ji;
      end
    end
    gnt_oh = gnt_vld ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin request arbiter for the shared instruction ROM,
// returning the registered ROM word to the granted CPU one cycle later.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N_CPUS = N_CPUS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CPUS-1:0]                req,
  input  logic [N_CPUS-1:0][ADDR_W-1:0]    addr,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [DATA_W-1:0]                rom_data,
  output logic [N_CPUS-1:0]                rsp_vld,
  output logic [DATA_W-1:0]                rsp_data,
  output logic [N_CPUS-1:0][CNT_W-1:0]     grant_cnt
);
  localparam int IW = N_CPUS > 1 ? $clog2(N_CPUS) : 1;
  logic [IW-1:0] ptr_q, ptr_d, gnt_idx;
  logic [N_CPUS-1:0] rsp_vld_q, rsp_vld_d, elig, gnt_oh;
  logic gnt_vld;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [N_CPUS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  // A CPU being answered still shows its old req, so it sits out this cycle.
  assign elig = req & ~rsp_vld_q;
  fetch_rr_picker #(.N(N_CPUS), .IW(IW)) u_picker (
    .elig(elig),
    .ptr(ptr_q),
    .gnt_vld(gnt_vld),
    .gnt_idx(gnt_idx),
    .gnt_oh(gnt_oh)
  );
  always_comb begin
    rom_addr = gnt_vld ? addr[gnt_idx] : '0;
    rsp_vld_d = gnt_vld ? gnt_oh : '0;
    rsp_data_d = gnt_vld ? rom_data : rsp_data_q;
    ptr_d = gnt_vld ? IW'(next_idx(32'(gnt_idx), N_CPUS)) : ptr_q;
    cnt_d = cnt_q;
    if (gnt_vld) cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      rsp_vld_q <= '0;
      rsp_data_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      cnt_q <= cnt_d;
    end
  end
  assign rsp_vld = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign grant_cnt = cnt_q;
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: vector table, corner sequences and randomized run
// checked against a cycle-level reference model of the arbiter.
module tb_imem_fetch_arbiter;
  localparam int N = 3;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [N-1:0][31:0] addr;
  logic [31:0] rom_addr, rom_data, rsp_data;
  logic [N-1:0] rsp_vld;
  logic [N-1:0][CW-1:0] grant_cnt;
  int tests = 0, fails = 0;
  int m_ptr, m_pend, m_g;
  int m_cnt[N];
  logic [31:0] m_data;
  typedef struct {
    logic [2:0] req;
    logic [31:0] rom;
    logic [2:0] vld;
    logic [31:0] data;
  } vec_t;
  vec_t tbl[15];
  imem_fetch_arbiter #(.N_CPUS(N), .ADDR_W(32), .DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .grant_cnt(grant_cnt)
  );
  assign rom_data = rom_addr ^ 32'hA5A5;
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    m_ptr = 0;
    m_pend = -1;
    m_data = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask
  task automatic mcheck();
    @(negedge clk);
    m_g = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (m_g < 0 && req[c] && c != m_pend) m_g = c;
    end
    check("rom_addr", rom_addr, m_g >= 0 ? addr[m_g] : 32'h0);
    check("rsp_vld", 32'(rsp_vld), m_pend >= 0 ? 32'(1) << m_pend : 32'h0);
    check("rsp_data", rsp_data, m_data);
    for (int i = 0; i < N; i++) check("grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i] % (1 << CW)));
  endtask
  task automatic madv();
    @(posedge clk);
    if (rst) model_reset();
    else if (m_g >= 0) begin
      m_data = addr[m_g] ^ 32'hA5A5;
      m_pend = m_g;
      m_ptr = (m_g + 1) % N;
      m_cnt[m_g]++;
    end else m_pend = -1;
    #1;
  endtask
  initial begin
    tbl[0]  = '{3'b111, 32'h000, 3'b000, 32'h0};
    tbl[1]  = '{3'b111, 32'h100, 3'b001, 32'hA5A5};
    tbl[2]  = '{3'b111, 32'h200, 3'b010, 32'hA4A5};
    tbl[3]  = '{3'b111, 32'h000, 3'b100, 32'hA7A5};
    tbl[4]  = '{3'b111, 32'h100, 3'b001, 32'hA5A5};
    tbl[5]  = '{3'b111, 32'h200, 3'b010, 32'hA4A5};
    tbl[6]  = '{3'b000, 32'h000, 3'b100, 32'hA7A5};
    tbl[7]  = '{3'b010, 32'h100, 3'b000, 32'hA7A5};
    tbl[8]  = '{3'b010, 32'h000, 3'b010, 32'hA4A5};
    tbl[9]  = '{3'b010, 32'h100, 3'b000, 32'hA4A5};
    tbl[10] = '{3'b010, 32'h000, 3'b010, 32'hA4A5};
    tbl[11] = '{3'b100, 32'h200, 3'b000, 32'hA4A5};
    tbl[12] = '{3'b101, 32'h000, 3'b100, 32'hA7A5};
    tbl[13] = '{3'b101, 32'h200, 3'b001, 32'hA5A5};
    tbl[14] = '{3'b000, 32'h000, 3'b100, 32'hA7A5};
    rst = 1'b1;
    req = 3'b111;
    addr[0] = 32'h000;
    addr[1] = 32'h100;
    addr[2] = 32'h200;
    model_reset();
    @(posedge clk);
    #1;
    mcheck();
    check("reset_vld", 32'(rsp_vld), 32'h0);
    madv();
    rst = 1'b0;
    for (int r = 0; r < 15; r++) begin
      req = tbl[r].req;
      mcheck();
      check($sformatf("tbl%0d_rom", r), rom_addr, tbl[r].rom);
      check($sformatf("tbl%0d_vld", r), 32'(rsp_vld), 32'(tbl[r].vld));
      check($sformatf("tbl%0d_data", r), rsp_data, tbl[r].data);
      if (r == 6)
        for (int i = 0; i < N; i++) check("full_load_cnt", 32'(grant_cnt[i]), 32'd2);
      madv();
    end
    req = 3'b010;
    rst = 1'b1;
    mcheck();
    check("midop_grant1", rom_addr, 32'h100);
    madv();
    rst = 1'b0;
    req = 3'b111;
    mcheck();
    check("midop_no_vld", 32'(rsp_vld), 32'h0);
    check("midop_ptr0", rom_addr, 32'h000);
    check("midop_data0", rsp_data, 32'h0);
    check("midop_cnt1", 32'(grant_cnt[1]), 32'h0);
    madv();
    rst = 1'b1;
    mcheck();
    madv();
    rst = 1'b0;
    req = 3'b001;
    repeat (34) begin
      mcheck();
      madv();
    end
    mcheck();
    check("cnt_wrap", 32'(grant_cnt[0]), 32'd1);
    madv();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++)
        if (!req[i] || m_pend == i) begin
          req[i] = 1'($urandom_range(0, 1));
          addr[i] = $urandom & 32'h0000_FFFC;
        end
      mcheck();
      madv();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Request-driven front end for the cluster's shared combinational instruction ROM. It replaces free-running grant rotation with per-CPU fetch requests.
- Round-robin arbitrates among CPUs that actually request, drives the single ROM address, and registers the ROM word.
- Returns the word to the granted CPU one cycle later with a per-CPU valid strobe. Sits between the CPUs' fetch ports and instruction_rom.

Parameters:
- N_CPUS, 3, number of requesting CPUs (>=1)
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction word width
- CNT_W, 16, width of per-CPU grant counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  N_CPUS  per-CPU fetch request; held until matching rsp_vld
- addr  in  N_CPUS x ADDR_W  per-CPU fetch address; stable while req high
- rom_addr  out  ADDR_W  address to shared ROM (combinational)
- rom_data  in  DATA_W  ROM read data, combinational from rom_addr
- rsp_vld  out  N_CPUS  one-hot (or zero) response strobe
- rsp_data  out  DATA_W  registered instruction word, broadcast to all CPUs
- grant_cnt  out  N_CPUS x CNT_W  per-CPU grant counters (debug/perf)

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_vld=0, rsp_data=0, all grant_cnt=0, priority pointer=0 (CPU0 highest).
  - Any in-flight grant is dropped: no rsp_vld in the cycle after rst deasserts.
- Eligibility in cycle t: eligible[i] = req[i] & ~rsp_vld[i]. A CPU being answered this cycle is not re-granted, because its req is still its old request.
- Arbitration (combinational in cycle t):
  - Search eligible from index ptr upward, modulo N_CPUS; the first hit is the grant g.
  - No eligible CPU: no grant, rom_addr=0.
- With a grant: rom_addr=addr[g]. At the edge ending t:
  - rsp_data<=rom_data; rsp_vld<=onehot(g).
  - ptr<=(g+1) mod N_CPUS.
  - grant_cnt[g]<=grant_cnt[g]+1, wrapping modulo 2^CNT_W.
- Without a grant: rsp_vld<=0; rsp_data and ptr hold.
- Latency and throughput:
  - Latency is exactly 1 cycle from grant to rsp_vld.
  - At most one grant per cycle.
  - A single continuous requester is served every other cycle. Two or more continuous requesters keep the ROM busy every cycle.
- Fairness: a CPU holding req waits at most N_CPUS-1 grant cycles.
- Protocol: a CPU may deassert req in the same cycle as its rsp_vld. Deasserting req before rsp_vld is illegal; the response is still delivered.
- Simultaneous events: a new request from CPU i in the cycle it receives rsp_vld is not eligible until the next cycle.
- Index arithmetic: unsigned, $clog2(N_CPUS) bits, explicit wrap at N_CPUS (no power-of-two assumption). N_CPUS=1: ptr constant 0.

Decomposition:
- Package imem_arb_pkg:
  - default N_CPUS/ADDR_W/DATA_W
  - cpu_idx_t typedef ($clog2 width, min 1)
  - function next_idx(idx) implementing the wrap
- Sub-module fetch_rr_picker (combinational):
  - inputs: eligible vector, ptr
  - outputs: grant valid, grant index, one-hot grant
- The top holds ptr, the response registers and the counters.

Test Plan:
- Reset: rst=1 two cycles with req=3'b111 -> rsp_vld=0, rsp_data=0, grant_cnt all 0. The first cycle after release grants CPU0 (rom_addr=addr[0]).
- Full load: req=3'b111, addr={0x200,0x100,0x000}, ROM word=addr^0xA5A5 -> grants 0,1,2,0,1,2. rsp_vld one cycle later is 001,010,100,... with matching rsp_data. After 6 cycles grant_cnt=2 each.
- Single requester: req=3'b010 held, CPU re-requests each time after rsp_vld -> rom_addr alternates 0x100/0, rsp_vld[1] every other cycle.
- Pointer: after a grant to CPU2, req=3'b101 both new -> CPU0 granted, then CPU2.
- Reset mid-op: CPU1 granted in cycle t, rst=1 in cycle t+1 -> no rsp_vld at t+1 onward; ptr=0, counters 0 after reset.
- Counter wrap: CNT_W=4, CPU0 alone granted 17 times -> grant_cnt[0]=1.
